// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared frame geometry and controller state encodings
package fc_pkg;
    localparam int FC_IN_LEN  = 16;
    localparam int FC_OUT_LEN = 4;
    localparam int FC_DW      = 32;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FETCH = 2'd2,
        ST_SEND  = 2'd3
    } fc_state_e;
endpackage

// File: rtl/fc_in_buf.sv
// rtl/fc_in_buf.sv - input vector buffer, one write port, combinational read port
module fc_in_buf #(
    parameter int DEPTH = fc_pkg::FC_IN_LEN,
    parameter int DW    = fc_pkg::FC_DW
) (
    input  logic                     S_AXIS_ACLK,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);
    // Contents are intentionally left unreset; they are only meaningful after a load.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fc_frame_ctrl.sv
// rtl/fc_frame_ctrl.sv - frame sequencer: load vector, run compute phase, stream results
module fc_frame_ctrl
    import fc_pkg::*;
#(
    parameter int IN_LEN  = fc_pkg::FC_IN_LEN,
    parameter int OUT_LEN = fc_pkg::FC_OUT_LEN,
    parameter int DW      = fc_pkg::FC_DW
) (
    input  logic                       S_AXIS_ACLK,
    input  logic                       S_AXIS_ARESETN,
    input  logic [DW-1:0]              S_AXIS_TDATA,
    input  logic                       S_AXIS_TVALID,
    output logic                       S_AXIS_TREADY,
    input  logic                       S_AXIS_TLAST,
    input  logic [$clog2(IN_LEN)-1:0]  vec_addr,
    output logic [DW-1:0]              vec_data,
    output logic                       Ti1,
    input  logic                       To1,
    output logic                       Ti2,
    input  logic                       To2,
    output logic [$clog2(OUT_LEN)-1:0] res_addr,
    input  logic [DW-1:0]              res_data,
    output logic [DW-1:0]              M_AXIS_TDATA,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic                       M_AXIS_TLAST,
    output logic                       frame_err
);
    localparam int AW = $clog2(IN_LEN);
    localparam int OW = $clog2(OUT_LEN);
    localparam logic [AW-1:0] WR_LAST  = AW'(IN_LEN - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(OUT_LEN - 1);

    fc_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] out_idx_q, out_idx_d;
    logic          frame_err_q, frame_err_d;
    logic [DW-1:0] out_q, out_d;
    logic          buf_we;
    logic          s_hs;
    logic          m_hs;

    // Ready is gated by reset so the upstream sees no acceptance while held in reset.
    assign S_AXIS_TREADY = (state_q == ST_LOAD) && S_AXIS_ARESETN;
    assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_hs          = M_AXIS_TVALID && M_AXIS_TREADY;

    assign Ti1           = (state_q == ST_CALC);
    assign Ti2           = (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign res_addr      = out_idx_q;
    assign M_AXIS_TDATA  = out_q;
    assign M_AXIS_TVALID = (state_q == ST_SEND) && To2;
    assign M_AXIS_TLAST  = (state_q == ST_SEND) && (out_idx_q == OUT_LAST);
    assign frame_err     = frame_err_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        out_idx_d   = out_idx_q;
        frame_err_d = frame_err_q;
        out_d       = out_q;
        buf_we      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_hs) begin
                    buf_we = 1'b1;
                    if (wr_ptr_q == WR_LAST) begin
                        state_d  = ST_CALC;
                        wr_ptr_d = '0;
                        if (!S_AXIS_TLAST) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (S_AXIS_TLAST) begin
                        // Short frame: drop it and restart the load from word 0.
                        frame_err_d = 1'b1;
                        wr_ptr_d    = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (To1) begin
                    state_d   = ST_FETCH;
                    out_idx_d = '0;
                end
            end
            ST_FETCH: begin
                out_d   = res_data;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (m_hs) begin
                    if (out_idx_q == OUT_LAST) begin
                        state_d   = ST_LOAD;
                        out_idx_d = '0;
                    end else begin
                        state_d   = ST_FETCH;
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            out_idx_q   <= '0;
            frame_err_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            out_idx_q   <= out_idx_d;
            frame_err_q <= frame_err_d;
            out_q       <= out_d;
        end
    end

    fc_in_buf #(
        .DEPTH (IN_LEN),
        .DW    (DW)
    ) u_in_buf (
        .S_AXIS_ACLK (S_AXIS_ACLK),
        .wr_en       (buf_we),
        .wr_addr     (wr_ptr_q),
        .wr_data     (S_AXIS_TDATA),
        .rd_addr     (vec_addr),
        .rd_data     (vec_data)
    );
endmodule

// File: tb/tb_fc_frame_ctrl.sv
// tb/tb_fc_frame_ctrl.sv - directed self-checking bench for fc_frame_ctrl
module tb_fc_frame_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [3:0]  vec_addr = '0;
    logic [31:0] vec_data;
    logic        ti1, to1, ti2, to2;
    logic [1:0]  res_addr;
    logic [31:0] res_data;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int calc_cnt = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];

    always #5 clk = ~clk;

    // Timer model: compute done after three cycles of Ti1, output always permitted.
    always @(posedge clk) begin
        if (!ti1) calc_cnt <= 0;
        else if (calc_cnt < 15) calc_cnt <= calc_cnt + 1;
    end
    assign to1      = ti1 && (calc_cnt >= 3);
    assign to2      = ti2;
    assign res_data = 32'hA0 + {30'd0, res_addr};

    always @(posedge clk) begin
        if (rstn && m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
        end
    end

    fc_frame_ctrl dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rstn),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .S_AXIS_TLAST   (s_tlast),
        .vec_addr       (vec_addr),
        .vec_data       (vec_data),
        .Ti1            (ti1),
        .To1            (to1),
        .Ti2            (ti2),
        .To2            (to2),
        .res_addr       (res_addr),
        .res_data       (res_data),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .M_AXIS_TLAST   (m_tlast),
        .frame_err      (frame_err)
    );

    task automatic send_frame(input int n, input logic [31:0] base, input int last_at);
        for (int i = 0; i < n; i++) begin
            s_tdata  = base + 32'(i);
            s_tlast  = (i == last_at);
            s_tvalid = 1'b1;
            for (int k = 0; k < 50 && !s_tready; k++) @(negedge clk);
            if (!s_tready) begin
                checks++; errors++;
                $display("FAIL send_timeout word=%0d tready=%b required=1", i, s_tready);
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_four_beats(input string tag);
        for (int k = 0; k < 200 && q_data.size() < 4; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (q_data.size() !== 4) begin
            errors++;
            $display("FAIL %s_beat_count got=%0d required=4", tag, q_data.size());
        end
        for (int b = 0; b < 4 && b < q_data.size(); b++) begin
            checks++;
            if (q_data[b] !== 32'hA0 + 32'(b) || q_last[b] !== (b == 3)) begin
                errors++;
                $display("FAIL %s_beat%0d got=%h/%b required=%h/%b", tag, b, q_data[b], q_last[b],
                         32'hA0 + 32'(b), (b == 3));
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ti1, ti2, m_tvalid, m_tlast, s_tready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl_outs got=%b required=00000", {ti1, ti2, m_tvalid, m_tlast, s_tready});
        end
        checks++;
        if (res_addr !== 2'd0 || m_tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data_outs got=%0d/%h required=0/00000000", res_addr, m_tdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got=%b/%b required=1/0", s_tready, frame_err);
        end
    endtask

    task automatic test_load();
        send_frame(16, 32'd1, 15);
        checks++;
        if (s_tready !== 1'b0 || ti1 !== 1'b1) begin
            errors++;
            $display("FAIL load_enter_calc tready/ti1 got=%b/%b required=0/1", s_tready, ti1);
        end
        vec_addr = 4'd5;
        #1;
        checks++;
        if (vec_data !== 32'd6) begin
            errors++;
            $display("FAIL vec_data_5 got=%h required=00000006", vec_data);
        end
        vec_addr = 4'd15;
        #1;
        checks++;
        if (vec_data !== 32'd16) begin
            errors++;
            $display("FAIL vec_data_15 got=%h required=00000010", vec_data);
        end
    endtask

    task automatic test_stream();
        q_data.delete(); q_last.delete();
        for (int k = 0; k < 20 && !to1; k++) @(negedge clk);
        checks++;
        if (to1 !== 1'b1 || ti1 !== 1'b1) begin
            errors++;
            $display("FAIL calc_wait to1/ti1 got=%b/%b required=1/1", to1, ti1);
        end
        @(negedge clk);
        checks++;
        if (ti1 !== 1'b0 || ti2 !== 1'b1) begin
            errors++;
            $display("FAIL calc_exit ti1/ti2 got=%b/%b required=0/1", ti1, ti2);
        end
        expect_four_beats("stream");
        checks++;
        if (s_tready !== 1'b1 || ti2 !== 1'b0) begin
            errors++;
            $display("FAIL stream_back_to_load tready/ti2 got=%b/%b required=1/0", s_tready, ti2);
        end
    endtask

    task automatic test_backpressure();
        q_data.delete(); q_last.delete();
        send_frame(16, 32'h100, 15);
        for (int k = 0; k < 100 && q_data.size() < 1; k++) @(negedge clk);
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'hA1 || m_tlast !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got=%b/%h/%b required=1/000000a1/0", c, m_tvalid, m_tdata, m_tlast);
            end
        end
        m_tready = 1'b1;
        expect_four_beats("bp");
    endtask

    task automatic test_tlast_err();
        send_frame(10, 32'h200, 9);
        checks++;
        if (frame_err !== 1'b1 || ti1 !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL short_frame err/ti1/tready got=%b/%b/%b required=1/0/1", frame_err, ti1, s_tready);
        end
        q_data.delete(); q_last.delete();
        send_frame(16, 32'h300, 15);
        vec_addr = 4'd0;
        #1;
        checks++;
        if (ti1 !== 1'b1 || vec_data !== 32'h300) begin
            errors++;
            $display("FAIL after_err_load ti1/vec0 got=%b/%h required=1/00000300", ti1, vec_data);
        end
        expect_four_beats("err");
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_sticky got=%b required=1", frame_err);
        end
    endtask

    task automatic test_reset_calc();
        q_data.delete(); q_last.delete();
        send_frame(16, 32'h400, 15);
        rstn = 1'b0;
        #1;
        checks++;
        if (ti1 !== 1'b0 || s_tready !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_calc ti1/tready/err got=%b/%b/%b required=0/0/0", ti1, s_tready, frame_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_calc_release tready got=%b required=1", s_tready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (q_data.size() !== 0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL no_partial_output beats/tvalid got=%0d/%b required=0/0", q_data.size(), m_tvalid);
        end
        send_frame(16, 32'h500, 15);
        expect_four_beats("post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_tlast_err();
        test_reset_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_frame_ctrl.md
FC_FRAME_CTRL -- requirements
Module: fc_frame_ctrl

Interface
REQ-001 Parameter IN_LEN, 16, input-vector words per frame.
REQ-002 Parameter OUT_LEN, 4, result words per frame.
REQ-003 Parameter DW, 32, data width.
REQ-004 S_AXIS_ACLK  in  1  clock; all logic on rising edge.
REQ-005 S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 S_AXIS_TDATA  in  DW  input vector word.
REQ-007 S_AXIS_TVALID  in  1  upstream word valid.
REQ-008 S_AXIS_TREADY  out  1  block accepts word.
REQ-009 S_AXIS_TLAST  in  1  last word of frame.
REQ-010 vec_addr  in  4  compute-array read index into input buffer.
REQ-011 vec_data  out  DW  buffer word at vec_addr, combinational.
REQ-012 Ti1  out  1  compute-phase enable to timer.
REQ-013 To1  in  1  timer: compute done.
REQ-014 Ti2  out  1  output-phase enable to timer.
REQ-015 To2  in  1  timer: output permitted.
REQ-016 res_addr  out  2  result read index; res_data valid one cycle later.
REQ-017 res_data  in  DW  result word from compute array.
REQ-018 M_AXIS_TDATA/TVALID/TREADY/TLAST  out/out/in/out  DW/1/1/1  result stream.
REQ-019 frame_err  out  1  sticky TLAST-mismatch flag.

Function
REQ-020 FSM states SHALL be LOAD, CALC, FETCH, SEND; reset state LOAD.
REQ-021 LOAD: TREADY=1; each handshake writes buffer[wr_ptr], wr_ptr++.
REQ-022 Handshake at wr_ptr=IN_LEN-1 SHALL move to CALC next cycle, wr_ptr to 0.
REQ-023 TLAST at wr_ptr<IN_LEN-1: frame_err<=1, wr_ptr<=0, frame discarded, stay LOAD.
REQ-024 TLAST absent at wr_ptr=IN_LEN-1: frame_err<=1, frame still proceeds to CALC.
REQ-025 CALC: Ti1=1, TREADY=0; hold until To1=1, then FETCH with out_idx=0.
REQ-026 Ti1, Ti2 SHALL be decoded only from the state register (glitch-free); Ti1 low at least one cycle between frames.
REQ-027 FETCH (1 cycle): Ti2=1, res_addr=out_idx; then SEND capturing res_data into output register.
REQ-028 SEND: Ti2=1, M_AXIS_TVALID=To2, TDATA from output register, TLAST=(out_idx=OUT_LEN-1).
REQ-029 TDATA/TLAST SHALL stay stable while TVALID=1 and TREADY=0; To2 drop withdraws TVALID only before handshake.
REQ-030 SEND handshake: out_idx=OUT_LEN-1 -> LOAD, else out_idx++ -> FETCH; throughput 1 beat / 2 cycles.
REQ-031 vec_data SHALL reflect buffer[vec_addr] in every state; contents meaningful only in CALC.
REQ-032 Buffer SHALL not be written outside LOAD; new frame overwrites in place.
REQ-033 Counters wrap only via explicit reset to 0 at frame/phase boundaries; no modulo overflow.

Reset
REQ-034 Reset SHALL force LOAD, wr_ptr=0, out_idx=0, frame_err=0.
REQ-035 During reset Ti1=Ti2=M_AXIS_TVALID=M_AXIS_TLAST=S_AXIS_TREADY=0, res_addr=0, M_AXIS_TDATA=0.
REQ-036 Buffer contents SHALL not be reset; undefined until written.
REQ-037 Reset mid-frame (any state) SHALL abort immediately; no partial output beats after release.

Structure
REQ-038 Shared package/header fc_pkg SHALL hold IN_LEN, OUT_LEN, DW and state encodings.
REQ-039 Buffer SHALL be sub-module fc_in_buf: IN_LEN x DW registers, one write port, one combinational read port.

Verification
REQ-040 Reset: assert 3 cycles -> all REQ-035 outputs 0; first cycle after release TREADY=1, frame_err=0.
REQ-041 Frame words 1..16, TLAST on 16th -> TREADY=0 and Ti1=1 next cycle; vec_addr=5 -> vec_data=6.
REQ-042 With real timer, res_data=0xA0+res_addr -> Ti1 falls cycle after To1; M_AXIS emits A0,A1,A2,A3, TLAST only on A3; then LOAD.
REQ-043 M_AXIS_TREADY low 5 cycles on beat A1 -> TVALID held, TDATA=A1 stable, no beat lost or duplicated.
REQ-044 TLAST on 10th word -> frame_err=1, no Ti1; following clean 16-word frame processed normally, frame_err stays 1.
REQ-045 Reset pulse during CALC -> Ti1=0 immediately, state LOAD; next full frame yields correct 4-beat output.
